// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and instruction field layout for the 16-bit core.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int WORD_W = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int REG_HI = 11;
    localparam int REG_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Memory port, decode handshake and redirect bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import proc_pkg::*;

    logic                  mem_req;
    logic [WORD_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  instr_valid;
    logic                  instr_taken;
    logic                  redirect;
    logic [WORD_W-1:0]     redirect_pc;
    logic [WORD_W-1:0]     instr;
    logic [OPC_HI-OPC_LO:0] opcode;
    logic [REG_HI-REG_LO:0] reg_fld;
    logic [IMM_HI-IMM_LO:0] imm8;
    logic [WORD_W-1:0]     imm_ext;
    logic [WORD_W-1:0]     instr_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, opcode, reg_fld, imm8, imm_ext, instr_pc,
        input  mem_ack, mem_rdata, instr_taken, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, opcode, reg_fld, imm8, imm_ext, instr_pc,
        output mem_ack, mem_rdata, instr_taken, redirect, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/sign_extend.sv
`default_nettype none
// ============================================================================
// Module      : sign_extend
// Description : Replicates the MSB of an IN_W-bit value up to OUT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_extend #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data
);

    assign o_data = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC, req/ack instruction read, instruction register and field split.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import proc_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_unit_if.master   bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_nxt;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] w_ir_nxt;
    logic [WORD_W-1:0] r_instr_pc;
    logic [WORD_W-1:0] w_instr_pc_nxt;
    logic [WORD_W-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

    // A redirect always beats a same-cycle ack: the returned word belongs to the old path.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_instr_pc_nxt = r_instr_pc;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.redirect) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = bus.mem_ack ? ST_FETCH : ST_DISCARD;
                end else if (bus.mem_ack) begin
                    w_ir_nxt       = bus.mem_rdata;
                    w_instr_pc_nxt = r_pc;
                    w_pc_nxt       = w_pc_inc;
                    w_state_nxt    = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                end
                if (bus.mem_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (bus.redirect) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = ST_FETCH;
                end else if (bus.instr_taken) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_req     = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
    assign bus.instr_valid = (r_state == ST_HOLD);
    assign bus.mem_addr    = r_pc;

    assign bus.instr    = r_ir;
    assign bus.opcode   = r_ir[OPC_HI:OPC_LO];
    assign bus.reg_fld  = r_ir[REG_HI:REG_LO];
    assign bus.imm8     = r_ir[IMM_HI:IMM_LO];
    assign bus.instr_pc = r_instr_pc;

    sign_extend #(
        .IN_W  (IMM_HI-IMM_LO+1),
        .OUT_W (WORD_W)
    ) u_sign_extend (
        .i_data (r_ir[IMM_HI:IMM_LO]),
        .o_data (bus.imm_ext)
    );

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit multi-cycle processor. It holds the program counter, issues word reads over a req/ack memory port, and latches the returned word in an instruction register. It presents the split fields, including the 8-bit immediate and its 16-bit sign-extended form, to decode, and holds them until decode takes them. It honours branch/jump redirects at any point.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  read request; held high until `mem_ack`.
- `mem_addr`  out  16  word address of the request; equals `pc`.
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  returned instruction word.
- `instr_valid`  out  1  the IR holds a live instruction.
- `instr_taken`  in  1  decode consumes the instruction. Only meaningful when `instr_valid` is high.
- `redirect`  in  1  one-cycle pulse that loads a new PC.
- `redirect_pc`  in  16  target of the redirect.
- `instr`  out  16  full IR contents.
- `opcode`  out  4  IR[15:12].
- `reg_fld`  out  4  IR[11:8].
- `imm8`  out  8  IR[7:0].
- `imm_ext`  out  16  `imm8` sign-extended to 16 bits.
- `instr_pc`  out  16  address the current IR word was fetched from.

## Operation
- FSM states:
  - IDLE: reset state, `mem_req`=0.
  - FETCH: `mem_req`=1.
  - DISCARD: `mem_req`=1. An outstanding read whose data is dropped.
  - HOLD: `instr_valid`=1.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH with `mem_ack` and no `redirect`:
  - IR <= `mem_rdata`, `instr_pc` <= `pc`, `pc` <= `pc`+1.
  - Next state HOLD.
- FETCH with `redirect` and no `mem_ack`:
  - `pc` <= `redirect_pc`.
  - Next state DISCARD, because the request cannot be retracted.
- FETCH with `redirect` and `mem_ack` in the same cycle:
  - Redirect wins. Data is dropped, `pc` <= `redirect_pc`.
  - Next state FETCH.
- DISCARD:
  - On `mem_ack`, drop the data and go to FETCH. The PC is unchanged.
  - A `redirect` in DISCARD overwrites `pc` and the state stays DISCARD unless `mem_ack` arrives in the same cycle.
  - With `mem_ack` and `redirect` together, `pc` <= `redirect_pc` and the next state is FETCH.
- HOLD with `instr_taken`: next state FETCH.
- HOLD with `redirect`, with or without `instr_taken`: `pc` <= `redirect_pc`, next state FETCH, and the IR is invalidated.
- HOLD with neither: IR and all outputs stay stable.
- PC arithmetic is 16-bit modulo. 16'hFFFF+1 wraps to 16'h0000 with no flag.
- `mem_addr` = `pc` combinationally.
- Field outputs and `imm_ext` are combinational from the IR.
- Reset values:
  - state IDLE, `pc`=RESET_PC.
  - IR=16'h0000, `instr_pc`=16'h0000.
  - `mem_req`=0, `instr_valid`=0, `imm_ext`=16'h0000.
- Reset mid-transaction abandons any outstanding read. The memory side must tolerate a dropped request.

## Timing
- `mem_req` and `instr_valid` are decoded from registered state only, with no combinational path from inputs.
- Zero-wait memory: `mem_ack` in the first FETCH cycle gives `instr_valid` high on the next cycle. The minimum fetch latency is 1 cycle from request to valid.
- Back-to-back throughput is one instruction per 2 cycles minimum: FETCH, then HOLD with immediate `instr_taken`.
- `instr_valid` falls the cycle after `instr_taken` or `redirect`.
- After a redirect in HOLD, `mem_addr`=`redirect_pc` on the next cycle.

## Structure
- Shared package `proc_pkg`:
  - state enum (IDLE, FETCH, DISCARD, HOLD).
  - field bit positions OPC_HI/LO, REG_HI/LO, IMM_HI/LO.
  - WORD_W=16.
- One sub-module: instantiate the existing `sign_extend` block to drive `imm_ext` from `imm8`. Do not re-implement the extension inline.

## Test plan
- Reset, then zero-wait memory returning 16'h3A85 at address 0: IDLE for 1 cycle, then `mem_addr`=0. After that, `instr_valid`=1 with `opcode`=3, `reg_fld`=A, `imm8`=85, `imm_ext`=16'hFF85, `instr_pc`=0.
- Three sequential fetches with 2-cycle memory latency and immediate `instr_taken`: `mem_addr` sequence 0,1,2, and each instruction is presented exactly once.
- Redirect to 16'h0040 while FETCH waits on a pending ack, then ack with 16'hDEAD: 16'hDEAD is never presented as valid. The next request is at 16'h0040.
- Simultaneous `mem_ack` and `redirect`=16'h0100 in FETCH: no `instr_valid`. The next cycle has `mem_addr`=16'h0100 in FETCH.
- HOLD with `instr_taken` low for 5 cycles: all outputs stable and `mem_req`=0. Then `redirect` together with `instr_taken`: refetch from the redirect target.
- PC at 16'hFFFF with fetch completing: next `mem_addr`=16'h0000. Asserting `rst_n` low mid-FETCH returns all outputs to reset values immediately (asynchronously).
